ro_edge_counter: RTL and testbench
==================================

# ro_edge_counter

Ring-oscillator edge counter sitting directly downstream of the inverter chain. It synchronises the free-running oscillator output into the reference clock domain and counts its rising edges over a programmable window of reference cycles. It reports the count with a DONE flag for the readout/calibration logic. Valid for oscillator frequencies below f(CLK_REF)/2; faster oscillators must be pre-divided upstream.

## Interface

- CNT_W, 16: width of edge count and DOUT.
- SEL_W, 3: width of SEL_CONV_TIME.
- WIN_MIN, 4: log2 of the shortest window; window W = 2^(WIN_MIN + SEL_CONV_TIME) reference cycles.

- CLK_REF  input  1  reference clock; all state on rising edge.
- RESET_COUNTER  input  1  asynchronous, active-high reset.
- OSC_IN  input  1  ring-oscillator output, asynchronous to CLK_REF.
- START  input  1  conversion request, sampled on CLK_REF.
- SEL_CONV_TIME  input  SEL_W  window select, captured when START is accepted.
- DOUT  output  CNT_W  edge count of last completed conversion.
- DONE  output  1  result valid; held until next accepted START.
- BUSY  output  1  conversion in progress.
- OVF  output  1  count saturated during last conversion.

## Operation

- Synchroniser: OSC_IN -> s1 -> s2 (two flops), s3 = delayed s2. Edge pulse e = s2 & ~s3. Runs continuously in all states.
- States: IDLE, COUNT, RESULT.
- IDLE: BUSY=0, DONE=0. START=1 -> COUNT; latch SEL_CONV_TIME; load window timer with W-1; clear edge count and OVF accumulator.
- COUNT: BUSY=1. Every cycle: if e, count += 1. At all-ones, count saturates and the overflow bit sets. Window timer decrements. When the timer is 0 and counting that cycle, go to RESULT. Load DOUT with the final count including that cycle's e. Load OVF. Set DONE=1, BUSY=0.
- RESULT: DONE=1, DOUT/OVF held. START=1 -> COUNT, same actions as from IDLE. DONE drops with BUSY rising. DOUT/OVF keep the old result until the new conversion completes.
- START while in COUNT is ignored. It is not queued.
- SEL_CONV_TIME changes during COUNT have no effect.
- Edges detected outside COUNT are never counted.
- Window timer width: WIN_MIN + 2^SEL_W - 1 bits. Arithmetic is unsigned. No wrap: the count saturates at 2^CNT_W - 1.

## Timing

- Reset (async assert, any state): state=IDLE. DOUT=0, DONE=0, BUSY=0, OVF=0. s1/s2/s3=0, count=0, timer=0.
- Reset during COUNT aborts the conversion. No result is produced.
- START accepted at edge t0: BUSY=1 after t0. The e values at edges t0+1 … t0+W are counted, exactly W samples. DONE=1, DOUT/OVF valid, BUSY=0 after edge t0+W.
- OSC_IN rising edge to e: 2-3 CLK_REF cycles, depending on phase. Edge-to-count alignment is therefore ±1 edge at window boundaries.
- Back-to-back: START held high in RESULT restarts immediately. DONE is high for exactly one cycle. The conversion period is W+1 cycles.
- START and RESET_COUNTER simultaneously: reset wins.

## Test plan

- OSC_IN tied 0, SEL=0 (W=16), START pulse -> after 16 cycles DOUT=0, OVF=0, DONE=1, BUSY=0; BUSY high for exactly 16 cycles.
- OSC_IN square wave period 4 CLK_REF, SEL=0, oscillator running ≥8 cycles before START -> DOUT=4; SEL=2 (W=64) -> DOUT=16; DONE held until the next START.
- CNT_W=4, OSC period 4, SEL=2 -> 16 edges attempted: DOUT=15, OVF=1. Next conversion with SEL=0 -> DOUT=4, OVF=0.
- START re-pulsed at cycles 3 and 10 of a W=16 conversion -> ignored. DONE at cycle 16 only. SEL changed mid-window -> window length unchanged.
- Assert RESET_COUNTER at cycle 8 of COUNT (async, mid-cycle) -> all outputs 0 immediately. Next START produces a full fresh conversion.
- START held high continuously, SEL=0 -> DONE pulses one cycle every 17 cycles. DOUT updates each pulse and is stable between pulses.

Source files
------------

// File: rtl/ro_edge_counter.sv
// Ring-oscillator edge counter: synchronises OSC_IN into the CLK_REF domain and
// counts its rising edges over a window of 2^(WIN_MIN+SEL_CONV_TIME) reference cycles.
module ro_edge_counter #(
  parameter int CNT_W   = 16,
  parameter int SEL_W   = 3,
  parameter int WIN_MIN = 4
) (
  input  logic             CLK_REF,
  input  logic             RESET_COUNTER,
  input  logic             OSC_IN,
  input  logic             START,
  input  logic [SEL_W-1:0] SEL_CONV_TIME,
  output logic [CNT_W-1:0] DOUT,
  output logic             DONE,
  output logic             BUSY,
  output logic             OVF
);

  localparam int TMR_W = WIN_MIN + (1 << SEL_W) - 1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_RESULT} state_t;

  state_t           r_state, w_stateNext;
  logic             r_s1, r_s2, r_s3;
  logic             w_edge;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_winLast;
  logic [TMR_W:0]   w_winSize;
  logic [CNT_W-1:0] r_count, w_countNext;
  logic             r_ovfAcc, w_ovfNext;
  logic [CNT_W-1:0] r_dout;
  logic             r_ovf;
  logic             w_start, w_last;

  // Two-flop synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge CLK_REF or posedge RESET_COUNTER) begin
    if (RESET_COUNTER) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= OSC_IN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge    = r_s2 & ~r_s3;
  assign w_winSize = (TMR_W+1)'(1) << (WIN_MIN + int'(SEL_CONV_TIME));
  assign w_winLast = TMR_W'(w_winSize - (TMR_W+1)'(1));

  always_ff @(posedge CLK_REF or posedge RESET_COUNTER) begin
    if (RESET_COUNTER) r_state <= S_IDLE;
    else               r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE, S_RESULT: begin
        if (START) begin
          w_stateNext = S_COUNT;
          w_start     = 1'b1;
        end
      end
      S_COUNT: begin
        if (r_timer == '0) begin
          w_stateNext = S_RESULT;
          w_last      = 1'b1;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Saturating increment; an edge arriving at all-ones is lost and flags overflow.
  always_comb begin
    w_countNext = r_count;
    w_ovfNext   = r_ovfAcc;
    if (w_edge) begin
      if (&r_count) w_ovfNext   = 1'b1;
      else          w_countNext = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_REF or posedge RESET_COUNTER) begin
    if (RESET_COUNTER) begin
      r_timer  <= '0;
      r_count  <= '0;
      r_ovfAcc <= 1'b0;
      r_dout   <= '0;
      r_ovf    <= 1'b0;
    end else if (w_start) begin
      r_timer  <= w_winLast;
      r_count  <= '0;
      r_ovfAcc <= 1'b0;
    end else if (r_state == S_COUNT) begin
      r_timer  <= r_timer - TMR_W'(1);
      r_count  <= w_countNext;
      r_ovfAcc <= w_ovfNext;
      if (w_last) begin
        r_dout <= w_countNext;
        r_ovf  <= w_ovfNext;
      end
    end
  end

  assign DOUT = r_dout;
  assign OVF  = r_ovf;
  assign BUSY = (r_state == S_COUNT);
  assign DONE = (r_state == S_RESULT);

endmodule

// File: tb/tb_ro_edge_counter.sv
// Scoreboard bench for ro_edge_counter: a default-width instance and a 4-bit-count
// instance share stimulus; each has its own expected-result queue and monitor.
module tb_ro_edge_counter;

  typedef struct {
    int win;
    int dout;
    int ovf;
  } exp_t;

  logic        CLK_REF;
  logic        RESET_COUNTER;
  logic        OSC_IN;
  logic        START;
  logic [2:0]  SEL_CONV_TIME;
  logic [15:0] doutA;
  logic        doneA, busyA, ovfA;
  logic [3:0]  doutB;
  logic        doneB, busyB, ovfB;
  logic        oscEn;

  exp_t expA[$];
  exp_t expB[$];
  int   passCount = 0;
  int   totalCount = 0;

  ro_edge_counter dutA (
    .CLK_REF(CLK_REF), .RESET_COUNTER(RESET_COUNTER), .OSC_IN(OSC_IN), .START(START),
    .SEL_CONV_TIME(SEL_CONV_TIME), .DOUT(doutA), .DONE(doneA), .BUSY(busyA), .OVF(ovfA)
  );

  ro_edge_counter #(.CNT_W(4)) dutB (
    .CLK_REF(CLK_REF), .RESET_COUNTER(RESET_COUNTER), .OSC_IN(OSC_IN), .START(START),
    .SEL_CONV_TIME(SEL_CONV_TIME), .DOUT(doutB), .DONE(doneB), .BUSY(busyB), .OVF(ovfB)
  );

  initial CLK_REF = 1'b0;
  always #5 CLK_REF = ~CLK_REF;

  // Oscillator with period of four reference cycles, phased away from CLK_REF edges.
  initial begin
    OSC_IN = 1'b0;
    #3;
    forever begin
      #20;
      if (oscEn) OSC_IN = ~OSC_IN;
      else       OSC_IN = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    totalCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK_REF);
    #1;
  endtask

  task automatic pushExp(input int win, input int n);
    exp_t e;
    e.win = win; e.dout = n; e.ovf = 0;
    expA.push_back(e);
    e.dout = (n > 15) ? 15 : n;
    e.ovf  = (n > 15) ? 1 : 0;
    expB.push_back(e);
  endtask

  // One-cycle START pulse with the expected edge count for this window.
  task automatic applyStimulus(input int sel, input int n);
    SEL_CONV_TIME = 3'(sel);
    START = 1'b1;
    pushExp(16 << sel, n);
    tick();
    START = 1'b0;
  endtask

  // Monitor for the wide instance: result, overflow and BUSY run length on each DONE rise.
  int   runA = 0, lastRunA = 0;
  logic prevBusyA = 1'b0, prevDoneA = 1'b0;
  always @(negedge CLK_REF) begin : monA
    exp_t e;
    if (RESET_COUNTER) begin
      runA = 0; prevBusyA = 1'b0; prevDoneA = 1'b0;
    end else begin
      if (busyA) runA++;
      else if (prevBusyA) begin lastRunA = runA; runA = 0; end
      if (doneA && !prevDoneA) begin
        if (expA.size() == 0) checkOutput("unexpected DONE A", 1, 0);
        else begin
          e = expA.pop_front();
          checkOutput("DOUT A", int'(doutA), e.dout);
          checkOutput("OVF A", int'(ovfA), e.ovf);
          checkOutput("window A", lastRunA, e.win);
          checkOutput("BUSY at DONE A", int'(busyA), 0);
        end
      end
      prevBusyA = busyA;
      prevDoneA = doneA;
    end
  end

  // Monitor for the 4-bit instance, where saturation is reachable.
  logic prevDoneB = 1'b0;
  always @(negedge CLK_REF) begin : monB
    exp_t e;
    if (RESET_COUNTER) prevDoneB = 1'b0;
    else begin
      if (doneB && !prevDoneB) begin
        if (expB.size() == 0) checkOutput("unexpected DONE B", 1, 0);
        else begin
          e = expB.pop_front();
          checkOutput("DOUT B", int'(doutB), e.dout);
          checkOutput("OVF B", int'(ovfB), e.ovf);
        end
      end
      prevDoneB = doneB;
    end
  end

  initial begin
    RESET_COUNTER = 1'b1;
    START = 1'b0;
    SEL_CONV_TIME = 3'd0;
    oscEn = 1'b0;
    repeat (3) tick();
    checkOutput("reset DOUT A", int'(doutA), 0);
    checkOutput("reset DONE A", int'(doneA), 0);
    checkOutput("reset BUSY A", int'(busyA), 0);
    checkOutput("reset OVF A", int'(ovfA), 0);
    checkOutput("reset DOUT B", int'(doutB), 0);
    RESET_COUNTER = 1'b0;
    repeat (2) tick();

    // Silent oscillator, shortest window.
    applyStimulus(0, 0);
    repeat (25) tick();
    checkOutput("DONE held idle osc", int'(doneA), 1);
    checkOutput("BUSY low after result", int'(busyA), 0);

    // Running oscillator: 4 edges per 16 cycles.
    oscEn = 1'b1;
    repeat (10) tick();
    applyStimulus(0, 4);
    repeat (20) tick();
    checkOutput("DONE held until next START", int'(doneA), 1);
    checkOutput("DOUT held until next START", int'(doutA), 4);
    applyStimulus(2, 16);
    repeat (70) tick();
    applyStimulus(0, 4);
    repeat (20) tick();

    // Mid-window START pulses and SEL change must not disturb the window.
    applyStimulus(0, 4);
    repeat (2) tick();
    START = 1'b1; tick(); START = 1'b0;
    tick();
    SEL_CONV_TIME = 3'd3;
    repeat (5) tick();
    START = 1'b1; tick(); START = 1'b0;
    repeat (5) tick();
    checkOutput("DONE low at cycle 15", int'(doneA), 0);
    checkOutput("BUSY high at cycle 15", int'(busyA), 1);
    tick();
    checkOutput("DONE high at cycle 16", int'(doneA), 1);
    checkOutput("BUSY low at cycle 16", int'(busyA), 0);
    SEL_CONV_TIME = 3'd0;
    repeat (4) tick();

    // Asynchronous reset mid-conversion aborts it.
    applyStimulus(0, 4);
    repeat (8) tick();
    #3 RESET_COUNTER = 1'b1;
    #1;
    checkOutput("abort DOUT A", int'(doutA), 0);
    checkOutput("abort BUSY A", int'(busyA), 0);
    checkOutput("abort DONE A", int'(doneA), 0);
    checkOutput("abort OVF A", int'(ovfA), 0);
    checkOutput("abort DOUT B", int'(doutB), 0);
    void'(expA.pop_back());
    void'(expB.pop_back());
    tick();
    RESET_COUNTER = 1'b0;
    repeat (20) tick();
    checkOutput("no result after abort", int'(doneA), 0);
    applyStimulus(0, 4);
    repeat (20) tick();

    // START held high: back-to-back conversions every 17 cycles.
    SEL_CONV_TIME = 3'd0;
    START = 1'b1;
    pushExp(16, 4);
    pushExp(16, 4);
    pushExp(16, 4);
    repeat (17) tick();
    checkOutput("b2b DONE pulse", int'(doneA), 1);
    tick();
    checkOutput("b2b DONE one cycle", int'(doneA), 0);
    checkOutput("b2b BUSY restart", int'(busyA), 1);
    repeat (33) tick();
    START = 1'b0;
    repeat (5) tick();

    checkOutput("scoreboard A drained", expA.size(), 0);
    checkOutput("scoreboard B drained", expB.size(), 0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
